alu_muldiv_seq: RTL and testbench

- Iterative multiply/divide unit that sits directly upstream of the HI/LO ALU stage.
- Accepts MULT/MULTU/DIV/DIVU operands from the execute stage and computes the result one bit per cycle.
- Delivers a {hi, lo} pair with a one-cycle done strobe, which the HI/LO stage latches into its HI and LO registers.
- Replaces the fixed-delay multiply model with real sequential hardware.

---
 rtl/alu_muldiv_seq_pkg.sv | 19 +
 rtl/alu_muldiv_seq_if.sv | 20 ++
 rtl/alu_muldiv_seq.sv | 155 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types for the iterative multiply/divide unit: control bundle,
// ALU function codes and the FSM state encoding exposed for debug.
package alu_muldiv_seq_pkg;

   typedef struct packed {
      logic Util_Control_clock;
      logic Util_Control_reset;
   } Util_Control_T;

   typedef enum logic [3:0] {
      Add, Addu, Sub, Subu, And, Or, Xor, Nor,
      Slt, Sltu, Mult, Multu, Div, Divu, Sll, Srl
   } Alu_Func_T;

   typedef enum logic [1:0] {
      ST_IDLE, ST_RUN, ST_FIX, ST_DONE
   } state_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/result bus between the execute stage (master) and the
// multiply/divide unit (slave).
interface alu_muldiv_seq_if #(
   parameter int DATA_W = 32
);
   // Handshake: start is a one-cycle request, accepted only while busy=0
   // (IDLE or DONE) with a mul/div func; done is a one-cycle strobe that
   // qualifies hi/lo, which then hold until the next done.
   logic                            start;
   alu_muldiv_seq_pkg::Alu_Func_T   func;
   logic [DATA_W-1:0]               data1;
   logic [DATA_W-1:0]               data2;
   logic                            busy;
   logic                            done;
   logic [DATA_W-1:0]               hi;
   logic [DATA_W-1:0]               lo;

   modport master (output start, func, data1, data2, input busy, done, hi, lo);
   modport slave  (input start, func, data1, data2, output busy, done, hi, lo);
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, feeding the HI/LO stage.
// Optional macro ALU_MULDIV_EARLY_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  Util_Control_T          ctrl,
   alu_muldiv_seq_if.slave        bus,
   output state_t                 o_state
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic                  w_clk;
   logic                  w_rst;
   state_t                r_state;
   state_t                w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [2*DATA_W-1:0]   r_acc;
   logic [2*DATA_W-1:0]   r_opb;
   logic [DATA_W-1:0]     r_mplier;
   logic [DATA_W-1:0]     r_raw1;
   logic                  r_is_div;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic                  r_div0;
   logic [DATA_W-1:0]     r_hi;
   logic [DATA_W-1:0]     r_lo;

   logic                  w_valid_func;
   logic                  w_accept;
   logic                  w_signed;
   logic                  w_is_div_in;
   logic                  w_neg1;
   logic                  w_neg2;
   logic [DATA_W-1:0]     w_mag1;
   logic [DATA_W-1:0]     w_mag2;
   logic [2*DATA_W-1:0]   w_mul_sum;
   logic [DATA_W:0]       w_diff;
   logic [2*DATA_W-1:0]   w_div_next;
   logic                  w_last;
   logic [2*DATA_W-1:0]   w_prod_fix;
   logic [DATA_W-1:0]     w_quo_fix;
   logic [DATA_W-1:0]     w_rem_fix;

   assign w_clk = ctrl.Util_Control_clock;
   assign w_rst = ctrl.Util_Control_reset;

   assign w_valid_func = bus.func inside {Mult, Multu, Div, Divu};
   assign w_accept     = bus.start && w_valid_func &&
                         (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_signed     = (bus.func == Mult) || (bus.func == Div);
   assign w_is_div_in  = (bus.func == Div) || (bus.func == Divu);
   assign w_neg1       = w_signed & bus.data1[DATA_W-1];
   assign w_neg2       = w_signed & bus.data2[DATA_W-1];
   assign w_mag1       = w_neg1 ? -bus.data1 : bus.data1;
   assign w_mag2       = w_neg2 ? -bus.data2 : bus.data2;

   // Multiply: product accumulates while the multiplicand walks left.
   assign w_mul_sum = r_acc + (r_mplier[0] ? r_opb : '0);

   // Restoring divide: r_acc holds {remainder, dividend/quotient}.
   assign w_diff     = r_acc[2*DATA_W-1:DATA_W-1] - {1'b0, r_opb[DATA_W-1:0]};
   assign w_div_next = w_diff[DATA_W] ? {r_acc[2*DATA_W-2:0], 1'b0}
                                      : {w_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};

`ifdef ALU_MULDIV_EARLY_EN
   assign w_last = (r_cnt == CNT_W'(DATA_W-1)) ||
                   (!r_is_div && (r_mplier[DATA_W-1:1] == '0));
`else
   assign w_last = (r_cnt == CNT_W'(DATA_W-1));
`endif

   assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
   assign w_quo_fix  = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
   assign w_rem_fix  = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

   always_comb begin
      w_next   = r_state;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_RUN;
         ST_RUN: begin
            bus.busy = 1'b1;
            if (w_last) w_next = ST_FIX;
         end
         ST_FIX: begin
            bus.busy = 1'b1;
            w_next   = ST_DONE;
         end
         ST_DONE: begin
            bus.done = 1'b1;
            w_next   = w_accept ? ST_RUN : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opb    <= '0;
         r_mplier <= '0;
         r_raw1   <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div_in;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            r_div0   <= w_is_div_in && (bus.data2 == '0);
            r_raw1   <= bus.data1;
            r_mplier <= w_mag2;
            r_acc    <= w_is_div_in ? {{DATA_W{1'b0}}, w_mag1} : '0;
            r_opb    <= {{DATA_W{1'b0}}, w_is_div_in ? w_mag2 : w_mag1};
         end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
               r_acc <= w_div_next;
            end else begin
               r_acc    <= w_mul_sum;
               r_opb    <= r_opb << 1;
               r_mplier <= r_mplier >> 1;
            end
         end else if (r_state == ST_FIX) begin
            // Divide by zero bypasses sign fixup and reports the raw dividend.
            if (r_is_div && r_div0) begin
               r_hi <= r_raw1;
               r_lo <= '1;
            end else if (r_is_div) begin
               r_hi <= w_rem_fix;
               r_lo <= w_quo_fix;
            end else begin
               {r_hi, r_lo} <= w_prod_fix;
            end
         end
      end
   end

   assign bus.hi  = r_hi;
   assign bus.lo  = r_lo;
   assign o_state = r_state;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq at DATA_W=4: directed vectors,
// randomized operations against an arithmetic model, and control corner cases.
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   Util_Control_T ctrl;
   state_t        dbg_state;
   int            checks = 0;
   int            failures = 0;
   logic [W-1:0]  exp_q[$];

   assign ctrl = {clk, rst};

   alu_muldiv_seq_if #(.DATA_W(W)) bus ();

   alu_muldiv_seq #(.DATA_W(W)) dut (
      .ctrl    (ctrl),
      .bus     (bus.slave),
      .o_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input Alu_Func_T f, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.func  = f;
      bus.data1 = a;
      bus.data2 = b;
      step();
      bus.start = 1'b0;
   endtask

   // lat counts rising edges from the start-sampling edge up to done being visible.
   task automatic wait_done(output int lat, output int busy_cyc, output bit seen);
      lat = 1;
      busy_cyc = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy === 1'b1) busy_cyc++;
         step();
         lat++;
      end
   endtask

   function automatic void model(input Alu_Func_T f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
      longint sa, sb, q, r;
      logic [2*W-1:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = '0;
      lo = '0;
      case (f)
         Multu: begin p = (2*W)'(longint'(a) * longint'(b)); hi = p[2*W-1:W]; lo = p[W-1:0]; end
         Mult:  begin p = (2*W)'(sa * sb); hi = p[2*W-1:W]; lo = p[W-1:0]; end
         Divu, Div: begin
            if (b == '0) begin
               hi = a;
               lo = '1;
            end else begin
               if (f == Divu) begin
                  q = longint'(a) / longint'(b);
                  r = longint'(a) % longint'(b);
               end else begin
                  q = sa / sb;
                  r = sa % sb;
               end
               hi = W'(r);
               lo = W'(q);
            end
         end
         default: ;
      endcase
   endfunction

   function automatic int exp_lat(input Alu_Func_T f, input logic [W-1:0] b);
      int k;
      logic [W-1:0] mag;
      k = 0;
      mag = (f == Mult && b[W-1]) ? -b : b;
      for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
      if (k == 0) k = 1;
`ifdef ALU_MULDIV_EARLY_EN
      if (f == Mult || f == Multu) return k + 2;
`endif
      return W + 2;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.func  = Add;
      bus.data1 = '0;
      bus.data2 = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.hi !== '0) begin failures++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
      checks++; if (bus.lo !== '0) begin failures++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
      checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_directed();
      Alu_Func_T    vf [7] = '{Multu, Mult, Mult, Divu, Div, Div, Divu};
      logic [W-1:0] va [7] = '{4'ha, 4'hd, 4'h8, 4'h7, 4'h9, 4'h8, 4'h5};
      logic [W-1:0] vb [7] = '{4'ha, 4'h5, 4'h8, 4'h3, 4'h2, 4'hf, 4'h0};
      logic [W-1:0] eh [7] = '{4'h6, 4'hf, 4'h4, 4'h1, 4'hf, 4'h0, 4'h5};
      logic [W-1:0] el [7] = '{4'h4, 4'h1, 4'h0, 4'h2, 4'hd, 4'h8, 4'hf};
      int lat, bc, el_lat;
      bit seen;
      for (int i = 0; i < 7; i++) begin
         el_lat = exp_lat(vf[i], vb[i]);
         drive_start(vf[i], va[i], vb[i]);
         wait_done(lat, bc, seen);
         checks++; if (!seen) begin failures++; $display("FAIL dir%0d_done: got none expected done", i); end
         checks++; if (lat != el_lat) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, el_lat); end
         checks++; if (bc != el_lat - 1) begin failures++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, el_lat - 1); end
         checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, bus.busy); end
         checks++; if (bus.hi !== eh[i]) begin failures++; $display("FAIL dir%0d_hi: got %h expected %h", i, bus.hi, eh[i]); end
         checks++; if (bus.lo !== el[i]) begin failures++; $display("FAIL dir%0d_lo: got %h expected %h", i, bus.lo, el[i]); end
         step();
         checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, bus.done); end
         checks++; if (bus.lo !== el[i]) begin failures++; $display("FAIL dir%0d_lo_hold: got %h expected %h", i, bus.lo, el[i]); end
      end
   endtask

   task automatic test_random();
      Alu_Func_T f;
      logic [W-1:0] a, b, mh, ml, ph, pl, xh, xl;
      int lat, bc, el_lat;
      bit seen;
      ph = 4'h5;
      pl = 4'hf;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: f = Mult;
            1: f = Multu;
            2: f = Div;
            default: f = Divu;
         endcase
         a = W'($urandom_range(0, 15));
         b = W'($urandom_range(0, 15));
         model(f, a, b, mh, ml);
         exp_q.push_back(mh);
         exp_q.push_back(ml);
         el_lat = exp_lat(f, b);
         drive_start(f, a, b);
         checks++; if (bus.hi !== ph || bus.lo !== pl) begin failures++; $display("FAIL rnd%0d_hold_in_run: got %h%h expected %h%h", n, bus.hi, bus.lo, ph, pl); end
         wait_done(lat, bc, seen);
         xh = exp_q.pop_front();
         xl = exp_q.pop_front();
         checks++; if (!seen) begin failures++; $display("FAIL rnd%0d_done: got none expected done", n); end
         checks++; if (lat != el_lat) begin failures++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, el_lat); end
         checks++; if (bus.hi !== xh || bus.lo !== xl) begin failures++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h: got %h%h expected %h%h", n, f, a, b, bus.hi, bus.lo, xh, xl); end
         ph = xh;
         pl = xl;
         step();
      end
   endtask

   task automatic test_busy_start();
      int lat, bc, extra;
      bit seen;
      drive_start(Multu, 4'h3, 4'h3);
      step();
      drive_start(Divu, 4'h7, 4'h3);
      wait_done(lat, bc, seen);
      checks++; if (!seen) begin failures++; $display("FAIL busy_start_done: got none expected done"); end
      checks++; if (bus.hi !== 4'h0 || bus.lo !== 4'h9) begin failures++; $display("FAIL busy_start_result: got %h%h expected 09", bus.hi, bus.lo); end
      extra = 0;
      step();
      for (int i = 0; i < 10; i++) begin
         if (bus.done === 1'b1) extra++;
         step();
      end
      checks++; if (extra != 0) begin failures++; $display("FAIL busy_start_extra_done: got %0d expected 0", extra); end
   endtask

   task automatic test_invalid_func();
      logic [W-1:0] h0, l0;
      int dn;
      h0 = bus.hi;
      l0 = bus.lo;
      drive_start(Add, 4'h5, 4'h3);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL invalid_busy: got %b expected 0", bus.busy); end
      checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL invalid_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      dn = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
         step();
      end
      checks++; if (dn != 0) begin failures++; $display("FAIL invalid_activity: got %0d expected 0", dn); end
      checks++; if (bus.hi !== h0 || bus.lo !== l0) begin failures++; $display("FAIL invalid_hold: got %h%h expected %h%h", bus.hi, bus.lo, h0, l0); end
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      bit seen;
      drive_start(Multu, 4'h5, 4'h3);
      wait_done(lat, bc, seen);
      checks++; if (!seen || bus.lo !== 4'hf || bus.hi !== 4'h0) begin failures++; $display("FAIL b2b_first: got done=%b %h%h expected done=1 0f", seen, bus.hi, bus.lo); end
      drive_start(Divu, 4'h9, 4'h2);
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy: got %b expected 1", bus.busy); end
      wait_done(lat, bc, seen);
      checks++; if (!seen) begin failures++; $display("FAIL b2b_second_done: got none expected done"); end
      checks++; if (lat != W + 2) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", lat, W + 2); end
      checks++; if (bus.hi !== 4'h1 || bus.lo !== 4'h4) begin failures++; $display("FAIL b2b_result: got %h%h expected 14", bus.hi, bus.lo); end
      step();
   endtask

   task automatic test_reset_mid();
      int dn;
      drive_start(Multu, 4'hb, 4'h7);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.hi !== '0 || bus.lo !== '0) begin failures++; $display("FAIL rstmid_hilo: got %h%h expected 00", bus.hi, bus.lo); end
      checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.done === 1'b1) dn++;
         step();
      end
      checks++; if (dn != 0) begin failures++; $display("FAIL rstmid_no_done: got %0d expected 0", dn); end
   endtask

   task automatic test_early();
      int lat, bc;
      bit seen;
      drive_start(Multu, 4'hf, 4'h1);
      wait_done(lat, bc, seen);
      checks++; if (!seen || lat != exp_lat(Multu, 4'h1)) begin failures++; $display("FAIL early_f1_latency: got %0d expected %0d", lat, exp_lat(Multu, 4'h1)); end
      checks++; if (bus.hi !== 4'h0 || bus.lo !== 4'hf) begin failures++; $display("FAIL early_f1_result: got %h%h expected 0f", bus.hi, bus.lo); end
      step();
      drive_start(Multu, 4'h7, 4'h0);
      wait_done(lat, bc, seen);
      checks++; if (!seen || lat != exp_lat(Multu, 4'h0)) begin failures++; $display("FAIL early_zero_latency: got %0d expected %0d", lat, exp_lat(Multu, 4'h0)); end
      checks++; if (bus.hi !== 4'h0 || bus.lo !== 4'h0) begin failures++; $display("FAIL early_zero_result: got %h%h expected 00", bus.hi, bus.lo); end
      step();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_start();
      test_invalid_func();
      test_back_to_back();
      test_reset_mid();
      test_early();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
